// File: rtl/ni_local_rx.sv
// ni_local_rx
//   Receive stage behind the router LOCAL output port. It takes credit-flow-
//   controlled flits in the order header, size, payload. The header and size
//   go into a one-entry descriptor register. Payload flits go into a FIFO,
//   and each payload entry is tagged with a "last" bit.
//
// Ports
//   clock, reset        : single clock; synchronous active-high reset
//   rx, data_in         : flit valid / flit from router tx/data_out[LOCAL]
//   credit_o            : storage free, drives router credit_i[LOCAL]
//   hdr_valid/target/size, hdr_ack : packet descriptor handshake
//   pl_valid/data/last, pl_ready   : payload FIFO head handshake
//   rx_pkt_count        : completed packets since reset (wrapping)
module ni_local_rx #(
    parameter int FLIT_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_in,
    output logic                  credit_o,
    output logic                  hdr_valid,
    output logic [FLIT_WIDTH-1:0] hdr_target,
    output logic [FLIT_WIDTH-1:0] hdr_size,
    input  logic                  hdr_ack,
    output logic                  pl_valid,
    output logic [FLIT_WIDTH-1:0] pl_data,
    output logic                  pl_last,
    input  logic                  pl_ready,
    output logic [CNT_WIDTH-1:0]  rx_pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {S_HEADER, S_SIZE, S_PAYLOAD} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_hdr_valid;
    logic [FLIT_WIDTH-1:0] r_hdr_target, r_hdr_size, r_remaining;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;

    logic [FLIT_WIDTH:0]   r_mem [FIFO_DEPTH];   // {last, data}
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;

    logic w_credit, w_xfer, w_push, w_pop, w_last_flit;

    // Credit depends only on registered state. Reset forces it low so the
    // router never sees credit while we are being cleared.
    always_comb begin
        w_credit = 1'b0;
        case (r_state)
            S_HEADER:  w_credit = !r_hdr_valid;
            S_SIZE:    w_credit = 1'b1;
            S_PAYLOAD: w_credit = (r_count < DEPTH_C);
            default:   w_credit = 1'b0;
        endcase
    end

    assign credit_o    = w_credit && !reset;
    assign w_xfer      = rx && credit_o;
    assign w_last_flit = (r_remaining == FLIT_WIDTH'(1));
    assign w_push      = w_xfer && (r_state == S_PAYLOAD);
    assign w_pop       = pl_valid && pl_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            case (r_state)
                S_HEADER:  w_state_nxt = S_SIZE;
                S_SIZE:    w_state_nxt = (data_in == '0) ? S_HEADER : S_PAYLOAD;
                S_PAYLOAD: w_state_nxt = w_last_flit ? S_HEADER : S_PAYLOAD;
                default:   w_state_nxt = S_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_HEADER;
            r_hdr_valid  <= 1'b0;
            r_hdr_target <= '0;
            r_hdr_size   <= '0;
            r_remaining  <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A set from the size flit cannot collide with an ack. The header
            // was only accepted while hdr_valid was low.
            if (r_hdr_valid && hdr_ack)
                r_hdr_valid <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    S_HEADER: r_hdr_target <= data_in;
                    S_SIZE: begin
                        r_hdr_size  <= data_in;
                        r_remaining <= data_in;
                        r_hdr_valid <= 1'b1;
                        if (data_in == '0)
                            r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                    end
                    S_PAYLOAD: begin
                        r_remaining <= r_remaining - FLIT_WIDTH'(1);
                        if (w_last_flit)
                            r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Payload FIFO. Storage is not reset; occupancy comes from the pointers and count only.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_last_flit, data_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign hdr_valid    = r_hdr_valid;
    assign hdr_target   = r_hdr_target;
    assign hdr_size     = r_hdr_size;
    assign pl_valid     = (r_count != '0);
    assign pl_data      = r_mem[r_rd_ptr][FLIT_WIDTH-1:0];
    assign pl_last      = r_mem[r_rd_ptr][FLIT_WIDTH];
    assign rx_pkt_count = r_pkt_cnt;

endmodule

// File: tb/tb_ni_local_rx.sv
module tb_ni_local_rx;

    logic        clock = 1'b0;
    logic        reset, rx, hdr_ack, pl_ready;
    logic [15:0] data_in;
    logic        credit_o, hdr_valid, pl_valid, pl_last;
    logic [15:0] hdr_target, hdr_size, pl_data, rx_pkt_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ni_local_rx #(.FLIT_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data_in(data_in),
        .credit_o(credit_o), .hdr_valid(hdr_valid), .hdr_target(hdr_target),
        .hdr_size(hdr_size), .hdr_ack(hdr_ack), .pl_valid(pl_valid),
        .pl_data(pl_data), .pl_last(pl_last), .pl_ready(pl_ready),
        .rx_pkt_count(rx_pkt_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge. Inputs change and outputs are sampled 2 time units later.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic ack_pulse();
        hdr_ack = 1'b1; cyc(); hdr_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; data_in = 16'h5555; hdr_ack = 1'b0; pl_ready = 1'b0;

        // Reset held 3 cycles with rx high
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_credit", credit_o, 0);
            chk("rst_hdr_valid", hdr_valid, 0);
            chk("rst_pl_valid", pl_valid, 0);
        end
        chk("rst_target", hdr_target, 16'h0);
        chk("rst_size", hdr_size, 16'h0);
        chk("rst_cnt", rx_pkt_count, 16'h0);
        reset = 1'b0; rx = 1'b0; #1;
        chk("rel_credit", credit_o, 1);
        cyc();
        chk("rel_no_capture", hdr_target, 16'h0);
        chk("rel_credit2", credit_o, 1);

        // Basic packet
        pl_ready = 1'b1;
        rx = 1'b1; data_in = 16'h0011; cyc();
        chk("b_credit_size", credit_o, 1);
        data_in = 16'h0003; cyc();
        chk("b_hdr_valid", hdr_valid, 1);
        chk("b_target", hdr_target, 16'h0011);
        chk("b_size", hdr_size, 16'h0003);
        chk("b_pl_empty", pl_valid, 0);
        data_in = 16'hA0A0; cyc();
        chk("b_pl0_v", pl_valid, 1);
        chk("b_pl0", pl_data, 16'hA0A0);
        chk("b_pl0_last", pl_last, 0);
        data_in = 16'hB0B0; cyc();
        chk("b_pl1", pl_data, 16'hB0B0);
        chk("b_pl1_last", pl_last, 0);
        data_in = 16'hC0C0; cyc();
        chk("b_pl2", pl_data, 16'hC0C0);
        chk("b_pl2_last", pl_last, 1);
        chk("b_cnt", rx_pkt_count, 16'd1);
        chk("b_credit_hdr_blk", credit_o, 0);
        rx = 1'b0; cyc();
        chk("b_drained", pl_valid, 0);
        ack_pulse();
        chk("b_ack_clear", hdr_valid, 0);
        chk("b_target_hold", hdr_target, 16'h0011);
        chk("b_credit_after_ack", credit_o, 1);

        // Backpressure (depth 4, size 6)
        pl_ready = 1'b0;
        rx = 1'b1; data_in = 16'h0044; cyc();
        data_in = 16'h0006; cyc();
        for (int i = 1; i <= 4; i++) begin
            data_in = 16'h1000 + 16'(i); cyc();
        end
        chk("bp_credit_full", credit_o, 0);
        chk("bp_head", pl_data, 16'h1001);
        data_in = 16'h1005; cyc();
        chk("bp_held_credit", credit_o, 0);
        chk("bp_head_stable", pl_data, 16'h1001);
        chk("bp_last_stable", pl_last, 0);
        pl_ready = 1'b1; cyc();
        chk("bp_credit_back", credit_o, 1);
        chk("bp_head2", pl_data, 16'h1002);
        pl_ready = 1'b0; cyc();
        chk("bp_full_again", credit_o, 0);
        chk("bp_head2_hold", pl_data, 16'h1002);
        pl_ready = 1'b1; data_in = 16'h1006; cyc();
        chk("bp_head3", pl_data, 16'h1003);
        chk("bp_credit3", credit_o, 1);
        cyc();
        rx = 1'b0;
        chk("bp_head4", pl_data, 16'h1004);
        chk("bp_cnt", rx_pkt_count, 16'd2);
        cyc();
        chk("bp_head5", pl_data, 16'h1005);
        chk("bp_head5_last", pl_last, 0);
        cyc();
        chk("bp_head6", pl_data, 16'h1006);
        chk("bp_head6_last", pl_last, 1);
        cyc();
        chk("bp_empty", pl_valid, 0);
        chk("bp_size", hdr_size, 16'd6);
        ack_pulse();

        // Zero-size packet
        rx = 1'b1; data_in = 16'h0022; cyc();
        data_in = 16'h0000; cyc();
        rx = 1'b0;
        chk("z_hdr_valid", hdr_valid, 1);
        chk("z_target", hdr_target, 16'h0022);
        chk("z_size", hdr_size, 16'h0);
        chk("z_cnt", rx_pkt_count, 16'd3);
        chk("z_in_header", credit_o, 0);
        cyc();
        chk("z_pl_valid", pl_valid, 0);
        ack_pulse();
        chk("z_credit", credit_o, 1);

        // Descriptor stall
        pl_ready = 1'b0;
        rx = 1'b1; data_in = 16'h0055; cyc();
        data_in = 16'h0001; cyc();
        data_in = 16'hAAAA; cyc();
        chk("d_stall_credit", credit_o, 0);
        chk("d_pl", pl_data, 16'hAAAA);
        chk("d_pl_last", pl_last, 1);
        chk("d_cnt", rx_pkt_count, 16'd4);
        data_in = 16'h0066; cyc();
        chk("d_still_stalled", credit_o, 0);
        chk("d_target_hold", hdr_target, 16'h0055);
        hdr_ack = 1'b1; cyc(); hdr_ack = 1'b0;
        chk("d_ack_credit", credit_o, 1);
        chk("d_ack_clear", hdr_valid, 0);
        cyc();
        chk("d_target2", hdr_target, 16'h0066);
        data_in = 16'h0001; cyc();
        chk("d_hdr_valid2", hdr_valid, 1);
        data_in = 16'hBBBB; cyc();
        rx = 1'b0;
        chk("d_pl_first_kept", pl_data, 16'hAAAA);
        chk("d_cnt2", rx_pkt_count, 16'd5);
        pl_ready = 1'b1; cyc();
        chk("d_pl_second", pl_data, 16'hBBBB);
        chk("d_pl_second_last", pl_last, 1);
        cyc();
        chk("d_empty", pl_valid, 0);
        ack_pulse();

        // Reset in the middle of a payload
        pl_ready = 1'b0;
        rx = 1'b1; data_in = 16'h0077; cyc();
        data_in = 16'h0005; cyc();
        data_in = 16'h2001; cyc();
        data_in = 16'h2002; cyc();
        chk("m_partial", pl_valid, 1);
        reset = 1'b1; rx = 1'b0; cyc();
        chk("m_flushed", pl_valid, 0);
        chk("m_hdr_clear", hdr_valid, 0);
        chk("m_cnt_clear", rx_pkt_count, 16'd0);
        reset = 1'b0; #1;
        chk("m_credit", credit_o, 1);
        pl_ready = 1'b1;
        rx = 1'b1; data_in = 16'h0033; cyc();
        data_in = 16'h0001; cyc();
        chk("m_target", hdr_target, 16'h0033);
        chk("m_size", hdr_size, 16'h0001);
        data_in = 16'h1234; cyc();
        rx = 1'b0;
        chk("m_pl", pl_data, 16'h1234);
        chk("m_pl_last", pl_last, 1);
        chk("m_pl_valid", pl_valid, 1);
        chk("m_cnt", rx_pkt_count, 16'd1);
        cyc();
        chk("m_empty", pl_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ni_local_rx.md
Name: ni_local_rx

Overview:
- Network-interface receive stage that sits directly downstream of the router LOCAL output port.
- Accepts credit-flow-controlled flits in the order header (target address), size, payload.
- Splits each packet into a one-entry header/size register and a payload FIFO, and presents both to the core side through valid/ready-style handshakes.
- Returns credit to the router only when storage is free.

Parameters:
- FLIT_WIDTH, 16, flit width in bits; same as router regflit.
- FIFO_DEPTH, 8, payload FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- clock, in, 1: single clock; all state is updated on the rising edge.
- reset, in, 1: synchronous, active-high.
- rx, in, 1: flit valid; driven by router tx[LOCAL].
- data_in, in, FLIT_WIDTH: flit; driven by router data_out[LOCAL].
- credit_o, out, 1: space available; drives router credit_i[LOCAL].
- hdr_valid, out, 1: header and size registers hold an unacknowledged packet descriptor.
- hdr_target, out, FLIT_WIDTH: captured header flit.
- hdr_size, out, FLIT_WIDTH: captured size flit (payload flit count).
- hdr_ack, in, 1: core consumes the descriptor.
- pl_valid, out, 1: payload FIFO not empty.
- pl_data, out, FLIT_WIDTH: payload FIFO head.
- pl_last, out, 1: head flit is the final payload flit of its packet.
- pl_ready, in, 1: core pops the payload head.
- rx_pkt_count, out, CNT_WIDTH: completed packets since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: FSM=S_HEADER; FIFO empty; hdr_valid=0; hdr_target=0; hdr_size=0; rx_pkt_count=0; remaining-count=0; credit_o=0 while reset is high.
- Flit transfer: a flit transfers on a rising edge where rx=1 and credit_o=1. rx while credit_o=0 is ignored; the router holds data_in.
- credit_o:
  - Combinational from registered state only; no path from rx, data_in, hdr_ack or pl_ready.
  - S_HEADER: credit_o = !hdr_valid.
  - S_SIZE: credit_o = 1.
  - S_PAYLOAD: credit_o = (fifo_count < FIFO_DEPTH).
- FSM, S_HEADER: on transfer, capture hdr_target ← data_in and go to S_SIZE.
- FSM, S_SIZE: on transfer, capture hdr_size ← data_in and remaining ← data_in.
  - Set hdr_valid=1 in the next cycle.
  - If data_in==0: increment rx_pkt_count and go to S_HEADER.
  - Otherwise go to S_PAYLOAD.
- FSM, S_PAYLOAD: on transfer, push {data_in, last=(remaining==1)} and decrement remaining.
  - When remaining==1, increment rx_pkt_count and go to S_HEADER.
  - Latency from a payload transfer to pl_valid is 1 cycle (registered FIFO write).
- Header handshake: hdr_valid && hdr_ack clears hdr_valid on the next edge. hdr_target and hdr_size hold their values until the next header is captured. The next packet's header is blocked until the ack takes effect.
- Payload handshake: pop on pl_valid && pl_ready. pl_data and pl_last must be stable while pl_valid=1 and pl_ready=0.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH; fifo_count has width log2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle leave the count unchanged and are legal at any count ≥1.
  - Push to a full FIFO cannot occur because credit_o=0. Pop on empty is ignored.
- Ordering: payload of packet N+1 may enter the FIFO while packet N payload is still queued; order is preserved. Core-side pairing of descriptor and payload follows pl_last.
- Size field: interpreted as unsigned FLIT_WIDTH. No maximum check; the block trusts the router framing.
- Reset mid-packet: the partial packet is discarded, the FIFO is flushed, rx_pkt_count is cleared and the FSM returns to S_HEADER. credit_o=1 in the first cycle after reset falls.

Test Plan:
- Reset: hold reset 3 cycles with rx=1 → credit_o=0, hdr_valid=0, pl_valid=0 throughout; credit_o=1 on the first cycle after release; no flit captured.
- Basic packet: flits 0x0011, 0x0003, 0xA0A0, 0xB0B0, 0xC0C0 back-to-back, pl_ready=1 →
  - hdr_valid=1 one cycle after the size transfer, with target 0x0011 and size 3.
  - pl_data sequence A0A0, B0B0, C0C0 with pl_last only on C0C0.
  - rx_pkt_count=1.
- Backpressure: FIFO_DEPTH=4, pl_ready=0, size 6 →
  - credit_o=0 after the 4th payload transfer; 5th flit is held by the router.
  - Pulse pl_ready for 1 cycle → credit_o=1 the next cycle.
  - All 6 flits delivered in order; pl_last on the 6th.
- Zero-size packet: 0x0022, 0x0000 → hdr_valid=1 with size 0; pl_valid stays 0; rx_pkt_count increments; FSM returns to S_HEADER.
- Descriptor stall: two packets back-to-back with hdr_ack=0 → credit_o=0 in S_HEADER for the second header. Assert hdr_ack for 1 cycle → credit_o=1 the next cycle; second header captured; first packet's payload unaffected.
- Reset mid-payload: assert reset after 2 of 5 payload flits →
  - FIFO empty, hdr_valid=0, rx_pkt_count=0.
  - A following clean packet (0x0033, 0x0001, 0x1234) is received correctly with pl_last=1.
